// File: rtl/ascon_pkg.sv
// Shared Ascon types, round constants and linear-layer rotation amounts.
package ascon_pkg;

  localparam int unsigned NUM_WORDS  = 5;
  localparam int unsigned WORD_WIDTH = 64;

  // Word 0 is x0 (index 0 of the packed array).
  typedef logic [NUM_WORDS-1:0][WORD_WIDTH-1:0] ascon_state_t;
  typedef logic [4:0] rounds_t;

  localparam rounds_t MAX_ROUNDS = 5'd16;

  localparam logic [7:0] ROUND_CONST [16] = '{
    8'h3c, 8'h2d, 8'h1e, 8'h0f, 8'hf0, 8'he1, 8'hd2, 8'hc3,
    8'hb4, 8'ha5, 8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
  };

  localparam int unsigned ROT_A [NUM_WORDS] = '{19, 61, 1, 10, 7};
  localparam int unsigned ROT_B [NUM_WORDS] = '{28, 39, 6, 17, 41};

  typedef enum logic [1:0] {StIdle, StRun, StDone} perm_state_e;

  function automatic logic [WORD_WIDTH-1:0] rotr(input logic [WORD_WIDTH-1:0] w,
                                                 input int unsigned amt);
    return (w >> amt) | (w << (WORD_WIDTH - amt));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant addition, substitution, linear diffusion.
module ascon_round
  import ascon_pkg::*;
(
  input  ascon_state_t state_i,
  input  logic [3:0]   round_i,
  output ascon_state_t state_o
);

  ascon_state_t pc_state;
  ascon_state_t ps_state;

  always_comb begin
    pc_state    = state_i;
    pc_state[2] = state_i[2] ^ {56'h0, ROUND_CONST[round_i]};
  end

  substitution_layer u_sbox (
    .state_i(pc_state),
    .state_o(ps_state)
  );

  always_comb begin
    state_o = ps_state;
    for (int w = 0; w < NUM_WORDS; w++) begin
      state_o[w] = ps_state[w] ^ rotr(ps_state[w], ROT_A[w]) ^ rotr(ps_state[w], ROT_B[w]);
    end
  end

endmodule

// File: rtl/substitution_layer.sv
// Ascon 5-bit S-box applied bit-sliced across all 64 columns of the state.
module substitution_layer
  import ascon_pkg::*;
(
  input  ascon_state_t state_i,
  output ascon_state_t state_o
);

  logic [WORD_WIDTH-1:0] x0, x1, x2, x3, x4;
  logic [WORD_WIDTH-1:0] t0, t1, t2, t3, t4;

  always_comb begin
    x0 = state_i[0] ^ state_i[4];
    x4 = state_i[4] ^ state_i[3];
    x2 = state_i[2] ^ state_i[1];
    x1 = state_i[1];
    x3 = state_i[3];
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    state_o = {x4, x3, x2, x1, x0};
  end

endmodule

// File: rtl/ascon_permutation.sv
// Iterative Ascon-p[rnd] engine, UNROLL rounds per cycle, valid/ready on both sides.
// Optional ASCON_PERM_ZEROIZE_EN: blanks state_o when idle and clears the register after use.
module ascon_permutation
  import ascon_pkg::*;
#(
  parameter int unsigned UNROLL = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [4:0]   rounds_i,
  input  ascon_state_t state_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output ascon_state_t state_o
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4)) begin : g_bad_unroll
    $error("ascon_permutation: UNROLL must be 1, 2 or 4");
  end

  localparam rounds_t UNROLL_R = rounds_t'(UNROLL);

  perm_state_e  st_q, st_d;
  ascon_state_t state_q, state_d;
  rounds_t      ri_q, ri_d;
  rounds_t      rnd_sat;
  rounds_t      ri_next;

  ascon_state_t lane_in  [UNROLL+1];
  ascon_state_t lane_out [UNROLL];

  assign lane_in[0] = state_q;

  // Lanes whose round index has run past the last round pass the state through.
  for (genvar k = 0; k < UNROLL; k++) begin : g_lane
    localparam rounds_t K = rounds_t'(k);
    rounds_t lane_idx;
    logic    lane_active;

    assign lane_idx    = ri_q + K;
    assign lane_active = lane_idx < MAX_ROUNDS;

    ascon_round u_round (
      .state_i(lane_in[k]),
      .round_i(lane_idx[3:0]),
      .state_o(lane_out[k])
    );

    assign lane_in[k+1] = lane_active ? lane_out[k] : lane_in[k];
  end

  assign rnd_sat = (rounds_i > MAX_ROUNDS) ? MAX_ROUNDS : rounds_i;
  assign ri_next = ri_q + UNROLL_R;

  always_comb begin
    st_d    = st_q;
    state_d = state_q;
    ri_d    = ri_q;
    unique case (st_q)
      StIdle: begin
        if (in_valid_i) begin
          state_d = state_i;
          ri_d    = MAX_ROUNDS - rnd_sat;
          st_d    = (rnd_sat == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        state_d = lane_in[UNROLL];
        if (ri_next >= MAX_ROUNDS) begin
          ri_d = MAX_ROUNDS;
          st_d = StDone;
        end else begin
          ri_d = ri_next;
        end
      end
      StDone: begin
        if (out_ready_i) begin
          st_d = StIdle;
`ifdef ASCON_PERM_ZEROIZE_EN
          state_d = '0;
`endif
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q    <= StIdle;
      state_q <= '0;
      ri_q    <= '0;
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      ri_q    <= ri_d;
    end
  end

  assign in_ready_o  = (st_q == StIdle);
  assign out_valid_o = (st_q == StDone);

`ifdef ASCON_PERM_ZEROIZE_EN
  assign state_o = out_valid_o ? state_q : '0;
`else
  assign state_o = state_q;
`endif

endmodule

// File: tb/tb_ascon_permutation.sv
// Bench for ascon_permutation: three instances (UNROLL 1/2/4) against a table-driven Ascon model.
module tb_ascon_permutation;
  import ascon_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [4:0]   rounds = '0;
  ascon_state_t state_in = '0;
  logic         ir [3];
  logic         ov [3];
  ascon_state_t so [3];
  ascon_state_t last_out [3];

  localparam int UNR [3] = '{1, 2, 4};

  always #5 clk = ~clk;

  ascon_permutation #(.UNROLL(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(ir[0]),
    .rounds_i(rounds), .state_i(state_in), .out_valid_o(ov[0]),
    .out_ready_i(out_ready), .state_o(so[0])
  );
  ascon_permutation #(.UNROLL(2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(ir[1]),
    .rounds_i(rounds), .state_i(state_in), .out_valid_o(ov[1]),
    .out_ready_i(out_ready), .state_o(so[1])
  );
  ascon_permutation #(.UNROLL(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(ir[2]),
    .rounds_i(rounds), .state_i(state_in), .out_valid_o(ov[2]),
    .out_ready_i(out_ready), .state_o(so[2])
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: S-box as a 5-bit lookup per column, constants from the closed form.
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };
  localparam int RA [5] = '{19, 61, 1, 10, 7};
  localparam int RB [5] = '{28, 39, 6, 17, 41};

  function automatic logic [63:0] ror(input logic [63:0] v, input int a);
    return (v >> a) | (v << (64 - a));
  endfunction

  function automatic ascon_state_t model(input ascon_state_t s, input int rnd);
    logic [63:0] x [5];
    logic [4:0]  col;
    logic [4:0]  sub;
    int          c;
    for (int w = 0; w < 5; w++) x[w] = s[w];
    for (int r = 16 - rnd; r < 16; r++) begin
      c = (((19 - r) << 4) | ((r - 4) & 15)) & 255;
      x[2] = x[2] ^ 64'(c);
      for (int b = 0; b < 64; b++) begin
        col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
        sub = SBOX[col];
        x[0][b] = sub[4];
        x[1][b] = sub[3];
        x[2][b] = sub[2];
        x[3][b] = sub[1];
        x[4][b] = sub[0];
      end
      for (int w = 0; w < 5; w++) x[w] = x[w] ^ ror(x[w], RA[w]) ^ ror(x[w], RB[w]);
    end
    return {x[4], x[3], x[2], x[1], x[0]};
  endfunction

  function automatic ascon_state_t rand_state();
    ascon_state_t s;
    for (int w = 0; w < 5; w++) s[w] = {$urandom(), $urandom()};
    return s;
  endfunction

  task automatic run_req(input ascon_state_t s, input logic [4:0] rnd, input int eff,
                         input string tag);
    ascon_state_t exp;
    bit           done [3];
    exp = model(s, eff);
    for (int u = 0; u < 3; u++) begin
      done[u] = 1'b0;
      chk($sformatf("%s/ready_u%0d", tag, UNR[u]), ir[u], 1'b1);
    end
    state_in  = s;
    rounds    = rnd;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int j = 0; j < 40 && !(done[0] && done[1] && done[2]); j++) begin
      for (int u = 0; u < 3; u++) begin
        if (!done[u] && ov[u]) begin
          done[u] = 1'b1;
          last_out[u] = so[u];
          chk($sformatf("%s/lat_u%0d", tag, UNR[u]), j + 1, 1 + (eff + UNR[u] - 1) / UNR[u]);
          chk($sformatf("%s/state_u%0d", tag, UNR[u]), so[u], exp);
        end
      end
      @(posedge clk); #1;
    end
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("%s/timeout_u%0d", tag, UNR[u]), done[u], 1'b1);
      chk($sformatf("%s/idle_valid_u%0d", tag, UNR[u]), ov[u], 1'b0);
`ifdef ASCON_PERM_ZEROIZE_EN
      chk($sformatf("%s/idle_zero_u%0d", tag, UNR[u]), so[u], '0);
`else
      chk($sformatf("%s/idle_hold_u%0d", tag, UNR[u]), so[u], exp);
`endif
    end
  endtask

  initial begin
    ascon_state_t s;
    ascon_state_t exp;
    logic [4:0]   r;

    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("rst/ready_u%0d", UNR[u]), ir[u], 1'b1);
      chk($sformatf("rst/valid_u%0d", UNR[u]), ov[u], 1'b0);
      chk($sformatf("rst/state_u%0d", UNR[u]), so[u], '0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_req('0, 5'd1, 1, "zero_r1");
    chk("zero_r1/w0", last_out[0][0], 64'h000964B00000004B);
    chk("zero_r1/w4", last_out[0][4], 64'h0);

    run_req(rand_state(), 5'd0, 0, "r0");
    for (int k = 0; k < 3; k++) begin
      run_req(rand_state(), 5'd12, 12, $sformatf("r12_%0d", k));
      run_req(rand_state(), 5'd8, 8, $sformatf("r8_%0d", k));
    end
    run_req(rand_state(), 5'd6, 6, "r6");
    s = rand_state();
    run_req(s, 5'd20, 16, "r20");
    run_req(s, 5'd16, 16, "r16");
    for (int k = 0; k < 4; k++) begin
      r = 5'($urandom_range(0, 16));
      run_req(rand_state(), r, int'(r), $sformatf("rnd_%0d", k));
    end

    // Back-pressure: hold the result in DONE while poking in_valid.
    s = rand_state();
    exp = model(s, 12);
    state_in  = s;
    rounds    = 5'd12;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int j = 0; j < 30 && !(ov[0] && ov[1] && ov[2]); j++) begin
      @(posedge clk); #1;
    end
    for (int c = 0; c < 10; c++) begin
      for (int u = 0; u < 3; u++) begin
        chk($sformatf("stall%0d/valid_u%0d", c, UNR[u]), ov[u], 1'b1);
        chk($sformatf("stall%0d/state_u%0d", c, UNR[u]), so[u], exp);
        chk($sformatf("stall%0d/ready_u%0d", c, UNR[u]), ir[u], 1'b0);
      end
      in_valid = ~in_valid;
      state_in = rand_state();
      @(posedge clk); #1;
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("release/ready_u%0d", UNR[u]), ir[u], 1'b1);
      chk($sformatf("release/valid_u%0d", UNR[u]), ov[u], 1'b0);
    end
    @(posedge clk); #1;
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("release2/valid_u%0d", UNR[u]), ov[u], 1'b0);
    end

    // Reset in the middle of a 12-round job.
    state_in = rand_state();
    rounds   = 5'd12;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("midrst/valid_u%0d", UNR[u]), ov[u], 1'b0);
      chk($sformatf("midrst/ready_u%0d", UNR[u]), ir[u], 1'b1);
      chk($sformatf("midrst/state_u%0d", UNR[u]), so[u], '0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      for (int u = 0; u < 3; u++) begin
        chk($sformatf("postrst%0d/valid_u%0d", c, UNR[u]), ov[u], 1'b0);
        chk($sformatf("postrst%0d/ready_u%0d", c, UNR[u]), ir[u], 1'b1);
        chk($sformatf("postrst%0d/state_u%0d", c, UNR[u]), so[u], '0);
      end
    end
    run_req(rand_state(), 5'd8, 8, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
